// File: rtl/ysyx_22040632_icache_nway.sv
// N-way set-associative instruction cache with burst line refill, uncached single-beat fetch and fence.i invalidate.
// Optional macro ICACHE_PERF_EN adds saturating hit/miss/uncached performance counters.
module ysyx_22040632_icache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 64,
    parameter int BUS_W      = 64,
    parameter int FETCH_W    = 128,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rrst_n,
    input  logic               fence_i,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_pc,
    input  logic               req_uncached,
    output logic               req_ready,
    output logic [FETCH_W-1:0] req_inst,
`ifdef ICACHE_PERF_EN
    output logic [31:0]        perf_hit,
    output logic [31:0]        perf_miss,
    output logic [31:0]        perf_unc,
`endif
    output logic               ar_valid,
    input  logic               ar_ready,
    output logic [ADDR_W-1:0]  ar_addr,
    output logic [7:0]         ar_len,
    output logic [2:0]         ar_size,
    input  logic               r_valid,
    input  logic [BUS_W-1:0]   r_data,
    input  logic               r_last,
    output logic               r_ready
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / BUS_W;
    localparam int BLOCKS = LINE_W / FETCH_W;
    localparam int FOFF_W = $clog2(FETCH_W / 8);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    if (WAYS < 1 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("WAYS must be a power of two in 1..8");
    end
    if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("SETS must be a power of two");
    end
    if (LINE_W % BUS_W != 0 || LINE_W % FETCH_W != 0 || FETCH_W % BUS_W != 0) begin : g_bad_widths
        $error("LINE_BYTES/BUS_W/FETCH_W are inconsistent");
    end

    typedef enum logic [2:0] {IDLE, MISS_AR, REFILL, UNC_AR, UNC_R, DONE} state_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [WAY_W-1:0]    victim_reg;
    logic                fence_pend_reg;
    logic [WAYS-1:0]     valid_reg  [SETS];
    logic [WAY_W-1:0]    rr_ptr_reg [SETS];
    logic [TAG_W-1:0]    tag_reg    [SETS][WAYS];
    logic [LINE_W-1:0]   data_reg   [SETS][WAYS];

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [BLK_W-1:0]    blk_sel;
    logic [WAYS-1:0]     hit_way;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_idx;
    logic [WAY_W-1:0]    victim;
    logic [FETCH_W-1:0]  hit_block;
    logic                refill_last;
    logic                unused_pc;

    assign req_idx   = req_pc[OFF_W +: IDX_W];
    assign req_tag   = req_pc[ADDR_W-1 -: TAG_W];
    assign unused_pc = ^req_pc;

    if (BLOCKS > 1) begin : g_blk
        assign blk_sel = req_pc[FOFF_W +: BLK_W];
    end else begin : g_blk_one
        assign blk_sel = '0;
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign hit_way[gi] = valid_reg[req_idx][gi] && (tag_reg[req_idx][gi] == req_tag);
    end
    assign hit_any = |hit_way;

    // Victim prefers the lowest invalid way; only a full set falls back to round-robin.
    always_comb begin
        hit_idx = '0;
        victim  = rr_ptr_reg[req_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i])
                hit_idx = WAY_W'(i);
            if (!valid_reg[req_idx][i])
                victim = WAY_W'(i);
        end
    end
    assign hit_block   = data_reg[req_idx][hit_idx][int'(blk_sel) * FETCH_W +: FETCH_W];
    assign refill_last = (state_reg == REFILL) && r_valid && r_last;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        req_inst   = '0;
        ar_valid   = 1'b0;
        ar_addr    = '0;
        ar_len     = 8'd0;
        ar_size    = 3'd0;
        r_ready    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_uncached) begin
                        state_next = UNC_AR;
                    end else if (hit_any) begin
                        req_ready = 1'b1;
                        req_inst  = hit_block;
                    end else begin
                        state_next = MISS_AR;
                    end
                end
            end
            MISS_AR: begin
                ar_valid = 1'b1;
                ar_addr  = {req_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                ar_len   = 8'(BEATS - 1);
                ar_size  = 3'($clog2(BUS_W / 8));
                if (ar_ready)
                    state_next = REFILL;
            end
            REFILL: begin
                r_ready = 1'b1;
                if (r_valid && r_last)
                    state_next = DONE;
            end
            DONE: begin
                // A fence applied on entry makes this miss; IDLE then restarts the fetch.
                if (req_valid && hit_any) begin
                    req_ready = 1'b1;
                    req_inst  = hit_block;
                end
                state_next = IDLE;
            end
            UNC_AR: begin
                ar_valid = 1'b1;
                ar_addr  = req_pc;
                ar_len   = 8'd0;
                ar_size  = 3'b010;
                if (ar_ready)
                    state_next = UNC_R;
            end
            UNC_R: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    req_ready  = 1'b1;
                    req_inst   = FETCH_W'(r_data);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            victim_reg     <= '0;
            fence_pend_reg <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s]  <= '0;
                rr_ptr_reg[s] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && state_next == MISS_AR)
                victim_reg <= victim;
            if (state_reg == REFILL && r_valid)
                beat_cnt_reg <= r_last ? '0 : beat_cnt_reg + 1'b1;

            // Fences seen mid-transaction are deferred until the line is safely written.
            if (refill_last) begin
                rr_ptr_reg[req_idx] <= (rr_ptr_reg[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                       : rr_ptr_reg[req_idx] + 1'b1;
                if (fence_pend_reg || fence_i) begin
                    for (int s = 0; s < SETS; s++)
                        valid_reg[s] <= '0;
                    fence_pend_reg <= 1'b0;
                end else begin
                    valid_reg[req_idx][victim_reg] <= 1'b1;
                end
            end else if ((state_reg == IDLE || state_reg == DONE) && fence_i) begin
                for (int s = 0; s < SETS; s++)
                    valid_reg[s] <= '0;
            end else if (state_reg == UNC_R && r_valid && (fence_pend_reg || fence_i)) begin
                for (int s = 0; s < SETS; s++)
                    valid_reg[s] <= '0;
                fence_pend_reg <= 1'b0;
            end else if (fence_i) begin
                fence_pend_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == REFILL && r_valid) begin
            data_reg[req_idx][victim_reg][int'(beat_cnt_reg) * BUS_W +: BUS_W] <= r_data;
            if (r_last)
                tag_reg[req_idx][victim_reg] <= req_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_reg, perf_miss_reg, perf_unc_reg;

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            perf_hit_reg  <= '0;
            perf_miss_reg <= '0;
            perf_unc_reg  <= '0;
        end else if (state_reg == IDLE) begin
            if (req_ready && perf_hit_reg != '1)
                perf_hit_reg <= perf_hit_reg + 1'b1;
            if (state_next == MISS_AR && perf_miss_reg != '1)
                perf_miss_reg <= perf_miss_reg + 1'b1;
            if (state_next == UNC_AR && perf_unc_reg != '1)
                perf_unc_reg <= perf_unc_reg + 1'b1;
        end
    end

    assign perf_hit  = perf_hit_reg;
    assign perf_miss = perf_miss_reg;
    assign perf_unc  = perf_unc_reg;
`endif

    a_one_hit: assert property (@(posedge clk) disable iff (!rrst_n)
        req_valid |-> $onehot0(hit_way));
    a_rlast: assert property (@(posedge clk) disable iff (!rrst_n)
        (state_reg == REFILL && r_valid) |-> (r_last == (beat_cnt_reg == BEAT_W'(BEATS - 1))));

endmodule

// File: tb/tb_ysyx_22040632_icache_nway.sv
// Directed bench for ysyx_22040632_icache_nway: acts as AXI slave over a synthetic memory and checks fetch data, AR fields, hit/miss and latency.
module tb_ysyx_22040632_icache_nway;
    logic         clk = 1'b0;
    logic         rrst_n;
    logic         fence_i;
    logic         req_valid;
    logic [31:0]  req_pc;
    logic         req_uncached;
    logic         req_ready;
    logic [127:0] req_inst;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [2:0]   ar_size;
    logic         r_valid;
    logic [63:0]  r_data;
    logic         r_last;
    logic         r_ready;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perf_hit, perf_miss, perf_unc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040632_icache_nway dut (
        .clk          (clk),
        .rrst_n       (rrst_n),
        .fence_i      (fence_i),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .req_uncached (req_uncached),
        .req_ready    (req_ready),
        .req_inst     (req_inst),
`ifdef ICACHE_PERF_EN
        .perf_hit     (perf_hit),
        .perf_miss    (perf_miss),
        .perf_unc     (perf_unc),
`endif
        .ar_valid     (ar_valid),
        .ar_ready     (ar_ready),
        .ar_addr      (ar_addr),
        .ar_len       (ar_len),
        .ar_size      (ar_size),
        .r_valid      (r_valid),
        .r_data       (r_data),
        .r_last       (r_last),
        .r_ready      (r_ready)
    );

    // Synthetic memory: each 64-bit word encodes its own address.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    function automatic logic [127:0] exp_block(input logic [31:0] pc);
        logic [31:0] b;
        b = pc & 32'hFFFF_FFF0;
        return {mem_word(b + 32'd8), mem_word(b)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit unc, input int ar_delay, input bit gaps,
                         input int fence_beat, output int n_ar, output logic [127:0] inst,
                         output int cycles);
        int ar_wait = 0;
        int beat = 0;
        int lastb;
        bit in_data = 0;
        bit fdone = 0;
        bit seen = 0;
        bit done = 0;
        logic [31:0] a0 = '0;
        logic [31:0] cap = '0;
        n_ar = 0;
        inst = '0;
        cycles = -1;
        lastb = unc ? 0 : 7;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            req_valid    = 1'b1;
            req_pc       = pc;
            req_uncached = unc;
            ar_ready     = !in_data && (ar_wait >= ar_delay);
            r_valid      = in_data && !(gaps && (cyc % 2 == 1));
            r_data       = unc ? mem_word(pc) : mem_word(cap + 32'(beat * 8));
            r_last       = r_valid && (beat == lastb);
            fence_i      = r_valid && (beat == fence_beat) && !fdone;
            #1;
            if (fence_i)
                fdone = 1;
            if (ar_valid) begin
                if (!seen) begin
                    a0 = ar_addr;
                    seen = 1;
                end else begin
                    chk("ar_addr_stable", 128'(ar_addr), 128'(a0));
                end
                if (ar_ready) begin
                    n_ar++;
                    chk("ar_addr", 128'(ar_addr), 128'(unc ? pc : (pc & 32'hFFFF_FFC0)));
                    chk("ar_len", 128'(ar_len), 128'(unc ? 8'd0 : 8'd7));
                    chk("ar_size", 128'(ar_size), 128'(unc ? 3'd2 : 3'd3));
                    cap = ar_addr;
                    in_data = 1;
                    beat = 0;
                    ar_wait = 0;
                    seen = 0;
                end else begin
                    ar_wait++;
                end
            end
            if (r_valid && r_ready) begin
                beat++;
                if (r_last)
                    in_data = 0;
            end
            if (req_ready) begin
                done = 1;
                inst = req_inst;
                cycles = cyc;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL fetch_timeout pc=%h no req_ready within budget", pc);
        end
        @(negedge clk);
        req_valid = 1'b0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        fence_i   = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          unc;
        int          ar_delay;
        bit          gaps;
        int          fence_beat;
        int          exp_n_ar;
        int          exp_cycles;
    } vec_t;

    initial begin
        vec_t vecs[21];
        int n_ar, cycles;
        logic [127:0] inst;
        int exp_hit = 0, exp_miss = 0, exp_unc = 0;

        //          pc            unc dly gap fence n_ar cyc
        vecs[0]  = '{32'h8000_0000, 0, 0, 0, -1, 1, 10};
        vecs[1]  = '{32'h8000_0010, 0, 0, 0, -1, 0, 0};
        vecs[2]  = '{32'h8000_0030, 0, 0, 0, -1, 0, 0};
        vecs[3]  = '{32'h8000_0800, 0, 0, 0, -1, 1, 10};
        vecs[4]  = '{32'h8000_1000, 0, 0, 0, -1, 1, 10};
        vecs[5]  = '{32'h8000_1800, 0, 0, 0, -1, 1, 10};
        vecs[6]  = '{32'h8000_0020, 0, 0, 0, -1, 0, 0};
        vecs[7]  = '{32'h8000_2000, 0, 0, 0, -1, 1, 10};
        vecs[8]  = '{32'h8000_0000, 0, 0, 0, -1, 1, 10};
        vecs[9]  = '{32'h8000_1000, 0, 0, 0, -1, 0, 0};
        vecs[10] = '{32'h8000_1800, 0, 0, 0, -1, 0, 0};
        vecs[11] = '{32'h8000_2010, 0, 0, 0, -1, 0, 0};
        vecs[12] = '{32'h8000_0800, 0, 0, 0, -1, 1, 10};
        vecs[13] = '{32'h8000_1000, 0, 0, 0, -1, 1, 10};
        vecs[14] = '{32'h8000_0030, 0, 0, 0, -1, 0, 0};
        vecs[15] = '{32'h1000_0004, 1, 0, 0, -1, 1, 2};
        vecs[16] = '{32'h1000_0004, 1, 0, 0, -1, 1, 2};
        vecs[17] = '{32'h8000_0100, 0, 5, 1, -1, 1, -1};
        vecs[18] = '{32'h8000_0110, 0, 0, 0, -1, 0, 0};
        vecs[19] = '{32'h8000_0200, 0, 0, 0,  3, 2, -1};
        vecs[20] = '{32'h8000_0210, 0, 0, 0, -1, 0, 0};

        rrst_n = 1'b0;
        fence_i = 1'b0;
        req_valid = 1'b0;
        req_pc = '0;
        req_uncached = 1'b0;
        ar_ready = 1'b0;
        r_valid = 1'b0;
        r_data = '0;
        r_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 128'(req_ready), 128'(0));
        chk("reset_ar_valid", 128'(ar_valid), 128'(0));
        chk("reset_r_ready", 128'(r_ready), 128'(0));
        chk("reset_req_inst", req_inst, 128'(0));
        rrst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            fetch(vecs[i].pc, vecs[i].unc, vecs[i].ar_delay, vecs[i].gaps, vecs[i].fence_beat,
                  n_ar, inst, cycles);
            chk($sformatf("v%0d_n_ar", i), 128'(n_ar), 128'(vecs[i].exp_n_ar));
            chk($sformatf("v%0d_inst", i), inst,
                vecs[i].unc ? {64'h0, mem_word(vecs[i].pc)} : exp_block(vecs[i].pc));
            if (vecs[i].exp_cycles >= 0)
                chk($sformatf("v%0d_cycles", i), 128'(cycles), 128'(vecs[i].exp_cycles));
            $display("vec %0d pc=%h unc=%0d n_ar=%0d cycles=%0d", i, vecs[i].pc, vecs[i].unc, n_ar, cycles);
            if (vecs[i].unc)
                exp_unc++;
            else if (vecs[i].exp_n_ar == 0)
                exp_hit++;
            else
                exp_miss += vecs[i].exp_n_ar;
        end

        // fence_i in IDLE alongside a hit: pre-fence data returned, then the line is gone.
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = 32'h8000_0220;
        req_uncached = 1'b0;
        fence_i = 1'b1;
        #1;
        chk("fence_idle_hit_ready", 128'(req_ready), 128'(1));
        chk("fence_idle_hit_inst", req_inst, exp_block(32'h8000_0220));
        $display("fence_idle pc=%h ready=%0d", req_pc, req_ready);
        exp_hit++;
        @(negedge clk);
        req_valid = 1'b0;
        fence_i = 1'b0;
        fetch(32'h8000_0200, 0, 0, 0, -1, n_ar, inst, cycles);
        chk("after_fence_n_ar", 128'(n_ar), 128'(1));
        chk("after_fence_inst", inst, exp_block(32'h8000_0200));
        $display("after_fence pc=80000200 n_ar=%0d cycles=%0d", n_ar, cycles);
        exp_miss++;

`ifdef ICACHE_PERF_EN
        chk("perf_hit", 128'(perf_hit), 128'(exp_hit));
        chk("perf_miss", 128'(perf_miss), 128'(exp_miss));
        chk("perf_unc", 128'(perf_unc), 128'(exp_unc));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
